// File: rtl/mio_bus_n.sv
// mio_bus_n: memory-mapped I/O bus controller between the CPU data port and
// NSLV slave channels. A CPU request is latched, decoded on a select field
// of the address and forwarded to one slave as a strobe held until that
// slave acknowledges. Completion is reported with a one-cycle m_done pulse,
// and m_err flags a decode error (and, optionally, a wait-state timeout).
//
// Optional feature macro: MIO_BUS_TMO_EN
//   defined     - 8-bit wait counter; a slave that does not ack within TMO
//                 wait cycles terminates the access with an error
//   not defined - no counter; REQ waits for ack indefinitely, TMO unused
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   m_addr, m_wdata   CPU address / write data
//   m_we, m_re        CPU write / read request (write wins if both high)
//   m_rdata           last completed read data
//   m_busy            transaction in progress, requests ignored
//   m_done, m_err     completion pulse and its error flag
//   s_addr, s_wdata   latched address / write data shared by all slaves
//   s_we, s_re        one-hot write / read strobes
//   s_rdata           packed slave read data, slave k at [k*DW +: DW]
//   s_ack             per-slave acknowledge
module mio_bus_n #(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned NSLV    = 4,
    parameter int unsigned SELW    = 2,
    parameter int unsigned SEL_LSB = 12,
    parameter int unsigned TMO     = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [AW-1:0]      m_addr,
    input  logic [DW-1:0]      m_wdata,
    input  logic               m_we,
    input  logic               m_re,
    output logic [DW-1:0]      m_rdata,
    output logic               m_busy,
    output logic               m_done,
    output logic               m_err,
    output logic [AW-1:0]      s_addr,
    output logic [DW-1:0]      s_wdata,
    output logic [NSLV-1:0]    s_we,
    output logic [NSLV-1:0]    s_re,
    input  logic [NSLV*DW-1:0] s_rdata,
    input  logic [NSLV-1:0]    s_ack
);

    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [DW-1:0]     wdata_q, wdata_d;
    logic [DW-1:0]     rdata_q, rdata_d;
    logic              wr_q, wr_d;
    logic [SELW-1:0]   sel_q, sel_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [NSLV-1:0]   s_we_q, s_we_d;
    logic [NSLV-1:0]   s_re_q, s_re_d;
`ifdef MIO_BUS_TMO_EN
    logic [CNT_W-1:0]  cnt_q, cnt_d;
`else
    logic              unused_tmo;
    assign unused_tmo = ^CNT_W'(TMO);
`endif

    logic [SELW-1:0]   sel_in;
    logic              sel_in_ok;
    logic              ack_sel;
    logic [DW-1:0]     rdata_sel;

    // Decode of the incoming request's select field.
    assign sel_in    = m_addr[SEL_LSB +: SELW];
    assign sel_in_ok = (32'(sel_in) < NSLV);

    // Acknowledge and read data of the latched slave only; others are ignored.
    always_comb begin
        ack_sel   = 1'b0;
        rdata_sel = '0;
        for (int unsigned k = 0; k < NSLV; k++) begin
            if (sel_q == SELW'(k)) begin
                ack_sel   = s_ack[k];
                rdata_sel = s_rdata[k*DW +: DW];
            end
        end
    end

    // Next-state logic; outputs are then derived from the next state so they
    // come straight out of flops.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        wr_d    = wr_q;
        sel_d   = sel_q;
        err_d   = 1'b0;
`ifdef MIO_BUS_TMO_EN
        cnt_d   = cnt_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (m_we || m_re) begin
                    addr_d  = m_addr;
                    wdata_d = m_wdata;
                    wr_d    = m_we;
                    sel_d   = sel_in;
`ifdef MIO_BUS_TMO_EN
                    cnt_d   = '0;
`endif
                    if (sel_in_ok) begin
                        state_d = ST_REQ;
                    end else begin
                        // Undecoded: report straight away, no slave touched.
                        state_d = ST_RESP;
                        err_d   = 1'b1;
                    end
                end
            end

            ST_REQ: begin
                // Ack is checked first so it wins over a coincident timeout.
                if (ack_sel) begin
                    if (!wr_q) begin
                        rdata_d = rdata_sel;
                    end
                    state_d = ST_RESP;
                end
`ifdef MIO_BUS_TMO_EN
                else if (cnt_q == CNT_W'(TMO)) begin
                    if (!wr_q) begin
                        rdata_d = '1;
                    end
                    state_d = ST_RESP;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end

            ST_RESP: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_RESP);

        s_we_d = '0;
        s_re_d = '0;
        if (state_d == ST_REQ) begin
            for (int unsigned k = 0; k < NSLV; k++) begin
                if (sel_d == SELW'(k)) begin
                    s_we_d[k] = wr_d;
                    s_re_d[k] = ~wr_d;
                end
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            wr_q    <= 1'b0;
            sel_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            s_we_q  <= '0;
            s_re_q  <= '0;
`ifdef MIO_BUS_TMO_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            wr_q    <= wr_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            s_we_q  <= s_we_d;
            s_re_q  <= s_re_d;
`ifdef MIO_BUS_TMO_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign m_rdata = rdata_q;
    assign m_busy  = busy_q;
    assign m_done  = done_q;
    assign m_err   = err_q;
    assign s_addr  = addr_q;
    assign s_wdata = wdata_q;
    assign s_we    = s_we_q;
    assign s_re    = s_re_q;

endmodule

// File: tb/tb_mio_bus_n.sv
// Testbench for mio_bus_n: a 4-slave instance exercised by directed and
// random transactions against a transaction-level expectation model, plus a
// 3-slave instance for undecoded accesses. Honours MIO_BUS_TMO_EN.
module tb_mio_bus_n;

    localparam int unsigned TMO = 15;
`ifdef MIO_BUS_TMO_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic [31:0]  m_addr, m_wdata, m_rdata;
    logic         m_we, m_re, m_busy, m_done, m_err;
    logic [31:0]  s_addr, s_wdata;
    logic [3:0]   s_we, s_re, s_ack;
    logic [127:0] s_rdata;

    logic [31:0]  n3_m_addr, n3_m_wdata, n3_m_rdata;
    logic         n3_m_we, n3_m_re, n3_m_busy, n3_m_done, n3_m_err;
    logic [31:0]  n3_s_addr, n3_s_wdata;
    logic [2:0]   n3_s_we, n3_s_re, n3_s_ack;
    logic [95:0]  n3_s_rdata;

    int tests_run    = 0;
    int tests_failed = 0;

    int          cur_dly  = 0;
    bit          noise_en = 1'b0;
    int          wcnt     = 0;
    logic [3:0]  slv_stb;
    logic        slv_ack;
    logic [31:0] mdl_rdata;

    mio_bus_n #(.AW(32), .DW(32), .NSLV(4), .SELW(2), .SEL_LSB(12), .TMO(TMO)) dut (
        .clk(clk), .rst(rst),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_we(m_we), .m_re(m_re),
        .m_rdata(m_rdata), .m_busy(m_busy), .m_done(m_done), .m_err(m_err),
        .s_addr(s_addr), .s_wdata(s_wdata), .s_we(s_we), .s_re(s_re),
        .s_rdata(s_rdata), .s_ack(s_ack)
    );

    mio_bus_n #(.AW(32), .DW(32), .NSLV(3), .SELW(2), .SEL_LSB(12), .TMO(TMO)) dut3 (
        .clk(clk), .rst(rst),
        .m_addr(n3_m_addr), .m_wdata(n3_m_wdata), .m_we(n3_m_we), .m_re(n3_m_re),
        .m_rdata(n3_m_rdata), .m_busy(n3_m_busy), .m_done(n3_m_done), .m_err(n3_m_err),
        .s_addr(n3_s_addr), .s_wdata(n3_s_wdata), .s_we(n3_s_we), .s_re(n3_s_re),
        .s_rdata(n3_s_rdata), .s_ack(n3_s_ack)
    );

    // Slave model: the strobed slave acks after cur_dly wait cycles;
    // unselected slaves optionally toggle ack randomly.
    always @(negedge clk) begin
        slv_stb = s_we | s_re;
        slv_ack = 1'b0;
        if (slv_stb != 4'b0) begin
            slv_ack = (wcnt == cur_dly);
            wcnt    = wcnt + 1;
        end else begin
            wcnt = 0;
        end
        for (int k = 0; k < 4; k++) begin
            s_ack[k] = slv_stb[k] ? slv_ack : (noise_en ? 1'($urandom) : 1'b0);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One transaction on the 4-slave instance, checked cycle by cycle.
    task automatic run_txn(input logic [31:0] addr, input logic [31:0] wdata,
                           input bit we, input bit re, input int dly,
                           input bit hold, input string tag);
        logic [1:0]  sel;
        logic [3:0]  exp_stb, got_dir, got_oth;
        bit          tmo;
        int          exp_cyc, cyc, stb_cnt, done_cyc;
        logic [31:0] slot;
        sel     = addr[13:12];
        exp_stb = 4'b0001 << sel;
        tmo     = TMO_EN && (dly > int'(TMO));
        exp_cyc = tmo ? int'(TMO) + 1 : dly + 1;
        slot    = s_rdata[sel*32 +: 32];
        if (!we) mdl_rdata = tmo ? 32'hFFFF_FFFF : slot;
        cur_dly = dly;

        @(negedge clk);
        m_addr = addr; m_wdata = wdata; m_we = we; m_re = re;
        @(negedge clk);
        cyc = 1; stb_cnt = 0; done_cyc = 0;
        while (done_cyc == 0 && cyc <= 300) begin
            if (cyc == 1) begin
                if (hold) begin
                    m_addr = 32'h0000_0040; m_we = 1'b0; m_re = 1'b1;
                end else begin
                    m_we = 1'b0; m_re = 1'b0;
                end
            end
            if ((s_we | s_re) != 4'b0) begin
                stb_cnt++;
                got_dir = we ? s_we : s_re;
                got_oth = we ? s_re : s_we;
                tests_run++;
                if (got_dir !== exp_stb || got_oth !== 4'b0 ||
                    s_addr !== addr || s_wdata !== wdata) begin
                    tests_failed++;
                    $display("FAIL %s strobe cyc%0d: got we=%b re=%b addr=%h wdata=%h, expected strobe %b (we=%0b) addr=%h wdata=%h",
                             tag, cyc, s_we, s_re, s_addr, s_wdata, exp_stb, we, addr, wdata);
                end
            end
            tests_run++;
            if (m_busy !== 1'b1) begin
                tests_failed++;
                $display("FAIL %s busy cyc%0d: got %b expected 1", tag, cyc, m_busy);
            end
            if (m_done === 1'b1) done_cyc = cyc;
            else begin
                @(negedge clk);
                cyc++;
            end
        end
        if (hold) begin
            m_we = 1'b0; m_re = 1'b0;
        end

        tests_run++;
        if (done_cyc == 0) begin
            tests_failed++;
            $display("FAIL %s done: no m_done within 300 cycles", tag);
        end else if (done_cyc != exp_cyc + 1 || stb_cnt != exp_cyc) begin
            tests_failed++;
            $display("FAIL %s latency: got done cyc %0d strobe cycles %0d, expected done cyc %0d strobe cycles %0d",
                     tag, done_cyc, stb_cnt, exp_cyc + 1, exp_cyc);
        end
        tests_run++;
        if (m_err !== tmo || m_rdata !== mdl_rdata) begin
            tests_failed++;
            $display("FAIL %s result: got err=%b rdata=%h expected err=%b rdata=%h",
                     tag, m_err, m_rdata, tmo, mdl_rdata);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests_run++;
            if (m_done !== 1'b0 || m_busy !== 1'b0 || s_we !== 4'b0 || s_re !== 4'b0) begin
                tests_failed++;
                $display("FAIL %s after: got done=%b busy=%b we=%b re=%b expected all 0",
                         tag, m_done, m_busy, s_we, s_re);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        mdl_rdata = 32'h0;
        tests_run++;
        if (m_rdata !== 32'h0 || m_busy !== 1'b0 || m_done !== 1'b0 || m_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_master: got rdata=%h busy=%b done=%b err=%b expected 0", m_rdata, m_busy, m_done, m_err);
        end
        tests_run++;
        if (s_we !== 4'b0 || s_re !== 4'b0 || s_addr !== 32'h0 || s_wdata !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_slave: got we=%b re=%b addr=%h wdata=%h expected 0", s_we, s_re, s_addr, s_wdata);
        end
        tests_run++;
        if (n3_m_busy !== 1'b0 || n3_m_rdata !== 32'h0 || n3_s_re !== 3'b0 || n3_s_we !== 3'b0) begin
            tests_failed++;
            $display("FAIL reset_n3: got busy=%b rdata=%h we=%b re=%b expected 0", n3_m_busy, n3_m_rdata, n3_s_we, n3_s_re);
        end
    endtask

    task automatic test_read_zero_wait();
        s_rdata = {32'h3333_3333, 32'h2222_2222, 32'hCAFE_0001, 32'h0000_1111};
        run_txn(32'h0000_1004, 32'h0, 1'b0, 1'b1, 0, 1'b0, "read_zero_wait");
    endtask

    task automatic test_write_wait();
        run_txn(32'h0000_3010, 32'h1234_5678, 1'b1, 1'b0, 3, 1'b0, "write_wait3");
    endtask

    task automatic test_decode_err();
        n3_s_ack   = 3'b111;
        n3_s_rdata = {32'hC3C3_0002, 32'hC3C3_0001, 32'hC3C3_0000};
        @(negedge clk);
        n3_m_addr = 32'h0000_2000; n3_m_re = 1'b1; n3_m_we = 1'b0;
        @(negedge clk);
        n3_m_re = 1'b0;
        tests_run++;
        if (n3_s_re !== 3'b100) begin
            tests_failed++;
            $display("FAIL n3_read strobe: got %b expected 100", n3_s_re);
        end
        @(negedge clk);
        tests_run++;
        if (n3_m_done !== 1'b1 || n3_m_err !== 1'b0 || n3_m_rdata !== 32'hC3C3_0002) begin
            tests_failed++;
            $display("FAIL n3_read result: got done=%b err=%b rdata=%h expected 1 0 c3c30002", n3_m_done, n3_m_err, n3_m_rdata);
        end
        for (int t = 0; t < 2; t++) begin
            @(negedge clk);
            n3_m_addr = (t == 0) ? 32'h0000_3000 : 32'h0000_3004;
            n3_m_we = (t == 1); n3_m_re = (t == 0);
            n3_m_wdata = 32'h5555_AAAA;
            @(negedge clk);
            n3_m_we = 1'b0; n3_m_re = 1'b0;
            tests_run++;
            if (n3_m_done !== 1'b1 || n3_m_err !== 1'b1 || n3_s_we !== 3'b0 ||
                n3_s_re !== 3'b0 || n3_m_rdata !== 32'hC3C3_0002) begin
                tests_failed++;
                $display("FAIL decode_err%0d: got done=%b err=%b we=%b re=%b rdata=%h expected 1 1 000 000 c3c30002",
                         t, n3_m_done, n3_m_err, n3_s_we, n3_s_re, n3_m_rdata);
            end
            @(negedge clk);
            tests_run++;
            if (n3_m_done !== 1'b0 || n3_m_busy !== 1'b0 || n3_s_we !== 3'b0 || n3_s_re !== 3'b0) begin
                tests_failed++;
                $display("FAIL decode_err%0d after: got done=%b busy=%b we=%b re=%b expected 0",
                         t, n3_m_done, n3_m_busy, n3_s_we, n3_s_re);
            end
        end
    endtask

    task automatic test_timeout();
        s_rdata[31:0] = 32'hDEAD_0000;
`ifdef MIO_BUS_TMO_EN
        run_txn(32'h0000_0008, 32'h0, 1'b0, 1'b1, 1000, 1'b0, "timeout_read");
`else
        cur_dly = 1000;
        @(negedge clk);
        m_addr = 32'h0000_0008; m_we = 1'b0; m_re = 1'b1;
        @(negedge clk);
        m_re = 1'b0;
        for (int c = 0; c < 40; c++) begin
            tests_run++;
            if (m_busy !== 1'b1 || s_re !== 4'b0001 || m_done !== 1'b0) begin
                tests_failed++;
                $display("FAIL no_ack_wait cyc%0d: got busy=%b re=%b done=%b expected 1 0001 0", c, m_busy, s_re, m_done);
            end
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mdl_rdata = 32'h0;
        tests_run++;
        if (m_busy !== 1'b0 || s_re !== 4'b0 || m_rdata !== 32'h0) begin
            tests_failed++;
            $display("FAIL no_ack_reset: got busy=%b re=%b rdata=%h expected 0", m_busy, s_re, m_rdata);
        end
`endif
        s_rdata[31:0] = 32'hBEEF_0015;
        run_txn(32'h0000_0010, 32'h0, 1'b0, 1'b1, int'(TMO), 1'b0, "ack_at_tmo");
    endtask

    task automatic test_both_high_busy();
        s_rdata = {32'h3333_0000, 32'h2222_0000, 32'h1111_0000, 32'h0000_0000};
        run_txn(32'h0000_2008, 32'hA5A5_5A5A, 1'b1, 1'b1, 2, 1'b1, "both_high_hold");
    endtask

    task automatic test_reset_mid();
        cur_dly = 1000;
        @(negedge clk);
        m_addr = 32'h0000_1020; m_we = 1'b0; m_re = 1'b1;
        @(negedge clk);
        m_re = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mdl_rdata = 32'h0;
        tests_run++;
        if (s_we !== 4'b0 || s_re !== 4'b0 || m_busy !== 1'b0 || m_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid: got we=%b re=%b busy=%b done=%b expected 0", s_we, s_re, m_busy, m_done);
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            tests_run++;
            if (m_done !== 1'b0 || m_busy !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset_mid_quiet: got done=%b busy=%b expected 0", m_done, m_busy);
            end
        end
        s_rdata[63:32] = 32'h0BAD_F00D;
        run_txn(32'h0000_1020, 32'h0, 1'b0, 1'b1, 1, 1'b0, "read_after_reset");
    endtask

    task automatic test_random();
        noise_en = 1'b1;
        for (int i = 0; i < 24; i++) begin
            int          sl, pick, d;
            logic [31:0] a, wd;
            sl   = $urandom_range(0, 3);
            pick = $urandom_range(0, 2);
            d    = $urandom_range(0, 5);
            if ($urandom_range(0, 5) == 0) d = int'(TMO) + 3;
            a  = ($urandom & 32'hFFFF_CFFF) | (32'(sl) << 12);
            wd = $urandom;
            s_rdata = {$urandom, $urandom, $urandom, $urandom};
            run_txn(a, wd, pick != 0, pick != 1, d, 1'b0, "random");
        end
        noise_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        m_addr = '0; m_wdata = '0; m_we = 1'b0; m_re = 1'b0;
        s_rdata = '0;
        n3_m_addr = '0; n3_m_wdata = '0; n3_m_we = 1'b0; n3_m_re = 1'b0;
        n3_s_ack = '0; n3_s_rdata = '0;
        mdl_rdata = '0;

        test_reset();
        test_read_zero_wait();
        test_write_wait();
        test_decode_err();
        test_timeout();
        test_both_high_busy();
        test_reset_mid();
        test_random();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mio_bus_n.md
# mio_bus_n

Parametrised memory-mapped I/O bus controller that connects the CPU data port to `NSLV` slave channels (VGA, PS/2, seven-segment, RAM, ROM window, ...). It replaces fixed one-cycle decoding with a registered request/acknowledge handshake, so slaves may insert wait states. Address decoding is configurable, and undecoded or unresponsive accesses are reported back as errors. It sits between the CPU and all MIO peripherals.

## Interface
Parameters:
- `AW`, 32, address width
- `DW`, 32, data width
- `NSLV`, 4, number of slave channels (1..2^`SELW`)
- `SELW`, 2, width of slave-select field
- `SEL_LSB`, 12, LSB of select field within address: sel = addr[`SEL_LSB` +: `SELW`]
- `TMO`, 15, wait-state limit in cycles (1..255)

Ports:
- `clk` in 1 — single clock, all logic on rising edge
- `rst` in 1 — synchronous, active-high reset
- `m_addr` in `AW` — CPU address
- `m_wdata` in `DW` — CPU write data
- `m_we` in 1 — write request
- `m_re` in 1 — read request
- `m_rdata` out `DW` — read data, held until the next read completes
- `m_busy` out 1 — transaction in progress; requests ignored while high
- `m_done` out 1 — one-cycle completion pulse
- `m_err` out 1 — valid with `m_done`: decode error or timeout
- `s_addr` out `AW` — latched address, shared by all slaves
- `s_wdata` out `DW` — latched write data, shared by all slaves
- `s_we` out `NSLV` — one-hot write strobe
- `s_re` out `NSLV` — one-hot read strobe
- `s_rdata` in `NSLV*DW` — slave read data; slave k uses bits [k*DW +: DW]
- `s_ack` in `NSLV` — slave k completes the access

## Operation
- States: IDLE, REQ, RESP.
- IDLE, `m_we|m_re` high:
  - Latch addr, wdata, direction and sel.
  - If `m_we` and `m_re` are both high, perform a write and ignore the read.
  - If sel >= `NSLV`: go to RESP with error.
  - Otherwise: go to REQ.
- REQ:
  - Drive `s_we[sel]` or `s_re[sel]` high continuously. All other strobe bits stay 0.
  - On `s_ack[sel]` high:
    - For a read, register `s_rdata[sel]` into `m_rdata`.
    - Go to RESP with no error.
  - `s_ack` bits of non-selected slaves are ignored.
- Wait counter (8-bit):
  - Clears on entry to REQ and increments each REQ cycle without ack.
  - When the counter equals `TMO`, go to RESP with error.
  - On a timed-out read, `m_rdata` is set to all ones.
- RESP:
  - `m_done` is 1 for exactly one cycle; `m_err` carries the error status.
  - Go to IDLE.
- `m_busy` is 1 in REQ and RESP.
- A decode-error write has no slave side effects. A decode-error read leaves `m_rdata` unchanged.
- `s_addr` and `s_wdata` hold their latched values until the next accepted request.

## Timing
- Reset values: state IDLE; `m_rdata` 0; `m_busy`, `m_done`, `m_err` 0; `s_we`, `s_re` 0; `s_addr`, `s_wdata` 0; counter 0.
- Zero-wait access:
  - Request sampled at edge 0.
  - Strobe high during cycle 1; ack sampled at edge 1.
  - `m_done` and `m_rdata` valid during cycle 2.
- Each slave wait cycle adds one cycle. Minimum issue interval is 3 cycles.
- Timeout: strobe is high for `TMO`+1 cycles, then `m_done` with `m_err`=1.
- Decode error: `m_done` with `m_err`=1 in cycle 1, and no strobe is ever raised.
- Ack arriving in the same cycle the counter hits `TMO`: the ack wins and no error is flagged.
- `rst` mid-transaction: all strobes and `m_busy` are 0 after that edge. No `m_done` pulse is generated. The outstanding transaction is lost.

## Configuration
- `MIO_BUS_TMO_EN` defined:
  - Wait counter and timeout path are compiled in, as described above.
- `MIO_BUS_TMO_EN` not defined:
  - No counter; REQ waits indefinitely for ack.
  - `m_err` is raised only for decode errors.
  - `TMO` is unused.

## Test plan
- Reset, then read slave 1 (addr 0x1004) with ack in the first REQ cycle and `s_rdata` slot 1 = 0xCAFE0001 -> `s_re`=4'b0010 for 1 cycle; `m_done` in cycle 2 with `m_rdata`=0xCAFE0001 and `m_err`=0.
- Write 0x12345678 to slave 3 (addr 0x3010), ack delayed 3 cycles -> `s_we`=4'b1000 for 4 cycles; `s_wdata`=0x12345678 and `s_addr`=0x3010 throughout; `m_done` 1 cycle after ack.
- `NSLV`=3, access to addr 0x3000 -> no strobe raised; `m_done` and `m_err` both 1 in cycle 1; `m_rdata` unchanged.
- With `MIO_BUS_TMO_EN`, `TMO`=15, read slave 0 with no ack -> `s_re[0]` high 16 cycles; then `m_done`=1, `m_err`=1, `m_rdata`=0xFFFFFFFF. Without the macro, `m_busy` stays high indefinitely.
- `m_we` and `m_re` both high for slave 2, plus a second request issued while busy -> only a write occurs; the second request is ignored and `m_done` pulses once.
- `rst` asserted while in REQ -> next cycle all strobes and `m_busy` are 0 and no `m_done` pulse; a fresh read afterwards completes normally.
